// File: rtl/instr_pkg.sv
// instr_pkg: shared definitions for the MIPS instruction decoder and encoder.
//   - instr_type_e : instruction category codes (R / I / J / illegal)
//   - OP_*         : opcode constants used by the category checker and tests
//   - *_LSB        : bit position of each field inside the 32-bit word
//   - encode_word  : assembles a 32-bit word from category and fields
package instr_pkg;

  typedef enum logic [1:0] {
    TYPE_R   = 2'b00,
    TYPE_I   = 2'b01,
    TYPE_J   = 2'b10,
    TYPE_BAD = 2'b11
  } instr_type_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam int OP_LSB     = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  // Fields that do not belong to the selected format are simply not used.
  function automatic logic [31:0] encode_word(
    input instr_type_e kind,
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    case (kind)
      TYPE_R: w = (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
                  (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | (32'(funct) << FUNCT_LSB);
      TYPE_I: w = (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
                  (32'(imm) << IMM_LSB);
      TYPE_J: w = (32'(op) << OP_LSB) | (32'(target) << TARGET_LSB);
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with first-word-fall-through output.
//   clk, rst       : clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data  : write request and data (ignored while full)
//   pop            : read request (ignored while empty)
//   rd_data        : head entry, zero while empty
//   full, empty    : occupancy flags
// DEPTH must be a power of two and at least 2.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_e;

  fifo_state_e      state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign full    = (state_reg == ST_FULL);
  assign empty   = (state_reg == ST_EMPTY);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // The head is read straight from storage so a word written into an empty
  // FIFO is visible one cycle later; gating keeps the output at zero while
  // the (unreset) storage holds stale data.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count_reg - CNT_W'(1);
    end
    case (state_reg)
      ST_EMPTY: begin
        if (do_push) state_next = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (do_push && !do_pop && count_reg == CNT_W'(DEPTH - 1)) begin
          state_next = ST_FULL;
        end else if (do_pop && !do_push && count_reg == CNT_W'(1)) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Push is blocked while full, so only a pop can leave this state.
        if (do_pop) state_next = ST_PARTIAL;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_EMPTY;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: assembles 32-bit MIPS words from a category plus fields,
// tags each with a sequential byte address and buffers them in a FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : request handshake; in_ready = FIFO not full
//   in_type         : 00 R, 01 I, 10 J, 11 illegal (always rejected)
//   in_op .. in_target : instruction fields
//   out_valid/ready : output handshake; word popped on out_valid & out_ready
//   out_instr, out_addr : encoded word and its byte address
//   err, err_cnt    : sticky rejection flag, saturating rejection count
// Optional: define INSTR_TYPE_CHECK_EN to also reject requests whose opcode
// does not match the category (R with op!=0, J with op not J/JAL, I with an
// R/J opcode).
module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
);
  import instr_pkg::*;

  instr_type_e       kind;
  logic [31:0]       word;
  logic              is_bad;
  logic              accept, push, reject, pop;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] next_addr_reg;
  logic              err_reg;
  logic [7:0]        err_cnt_reg;

  assign kind = instr_type_e'(in_type);
  assign word = encode_word(kind, in_op, in_rs, in_rt, in_rd, in_shamt,
                            in_funct, in_imm, in_target);

  always_comb begin
    is_bad = (kind == TYPE_BAD);
`ifdef INSTR_TYPE_CHECK_EN
    case (kind)
      TYPE_R:  if (in_op != OP_RTYPE) is_bad = 1'b1;
      TYPE_J:  if (in_op != OP_J && in_op != OP_JAL) is_bad = 1'b1;
      TYPE_I:  if (in_op == OP_RTYPE || in_op == OP_J || in_op == OP_JAL) is_bad = 1'b1;
      default: is_bad = 1'b1;
    endcase
`endif
  end

  // A rejected request still completes its handshake; it just never
  // reaches the FIFO and does not consume an address.
  assign in_ready  = ~fifo_full;
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~is_bad;
  assign reject    = accept & is_bad;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign err       = err_reg;
  assign err_cnt   = err_cnt_reg;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32 + ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({word, next_addr_reg}),
    .pop     (pop),
    .rd_data ({out_instr, out_addr}),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      next_addr_reg <= BASE_ADDR;
      err_reg       <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      // Wraps naturally modulo 2^ADDR_W.
      if (push) next_addr_reg <= next_addr_reg + ADDR_W'(4);
      if (reject) begin
        err_reg <= 1'b1;
        if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. Two instances share all inputs:
// dut_a starts at address 0, dut_b at 0xFFFFFFFC to exercise wrap-around.
module tb_instr_encoder;
  import instr_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  in_type = '0;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;

  logic        in_ready_a, out_valid_a, err_a;
  logic [31:0] out_instr_a, out_addr_a;
  logic [7:0]  err_cnt_a;
  logic        in_ready_b, out_valid_b, err_b;
  logic [31:0] out_instr_b, out_addr_b;
  logic [7:0]  err_cnt_b;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_type(in_type), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_instr(out_instr_a),
    .out_addr(out_addr_a), .err(err_a), .err_cnt(err_cnt_a)
  );

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_type(in_type), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b),
    .out_addr(out_addr_b), .err(err_b), .err_cnt(err_cnt_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Encoding by field weights (powers of two) rather than bit slicing.
  function automatic logic [31:0] ref_word(
    input logic [1:0] t, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
    input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] hi;
    hi = 32'(op) * 32'h0400_0000;
    case (t)
      2'b00:   return hi + 32'(rs) * 32'h0020_0000 + 32'(rt) * 32'h0001_0000 +
                      32'(rd) * 32'h0000_0800 + 32'(sh) * 32'h40 + 32'(fn);
      2'b01:   return hi + 32'(rs) * 32'h0020_0000 + 32'(rt) * 32'h0001_0000 + 32'(imm);
      default: return hi + 32'(tgt);
    endcase
  endfunction

  function automatic bit ref_bad(input logic [1:0] t, input logic [5:0] op);
    if (t == 2'b11) return 1'b1;
`ifdef INSTR_TYPE_CHECK_EN
    if (t == 2'b00 && op != 6'd0) return 1'b1;
    if (t == 2'b10 && !(op == 6'd2 || op == 6'd3)) return 1'b1;
    if (t == 2'b01 && (op == 6'd0 || op == 6'd2 || op == 6'd3)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  logic [31:0] q_word[$];
  int unsigned q_idx[$];   // acceptance index since reset; address = base + 4*index
  int unsigned n_acc = 0;
  bit          m_err = 0;
  int          m_cnt = 0;
  bit          m_live = 0;

  // Compare on the falling edge, then advance the model to the state the
  // DUT will hold after the coming rising edge (inputs are stable here).
  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ew, ea, eb;
    if (m_live) begin
      ev = (q_word.size() != 0);
      ew = ev ? q_word[0] : 32'h0;
      ea = ev ? 32'(q_idx[0] * 4) : 32'h0;
      eb = ev ? BASE_B + 32'(q_idx[0] * 4) : 32'h0;
      chk("in_ready_a",  64'(in_ready_a),  64'(q_word.size() < DEPTH));
      chk("in_ready_b",  64'(in_ready_b),  64'(q_word.size() < DEPTH));
      chk("out_valid_a", 64'(out_valid_a), 64'(ev));
      chk("out_valid_b", 64'(out_valid_b), 64'(ev));
      chk("out_instr_a", 64'(out_instr_a), 64'(ew));
      chk("out_instr_b", 64'(out_instr_b), 64'(ew));
      chk("out_addr_a",  64'(out_addr_a),  64'(ea));
      chk("out_addr_b",  64'(out_addr_b),  64'(eb));
      chk("err_a",       64'(err_a),       64'(m_err));
      chk("err_b",       64'(err_b),       64'(m_err));
      chk("err_cnt_a",   64'(err_cnt_a),   64'(m_cnt));
      chk("err_cnt_b",   64'(err_cnt_b),   64'(m_cnt));
    end
    if (rst) begin
      q_word.delete();
      q_idx.delete();
      n_acc  = 0;
      m_err  = 0;
      m_cnt  = 0;
      m_live = 1;
    end else if (m_live) begin
      bit can_push;
      can_push = (q_word.size() < DEPTH);
      if (q_word.size() != 0 && out_ready) begin
        void'(q_word.pop_front());
        void'(q_idx.pop_front());
      end
      if (in_valid && can_push) begin
        if (ref_bad(in_type, in_op)) begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          q_word.push_back(ref_word(in_type, in_op, in_rs, in_rt, in_rd, in_shamt,
                                    in_funct, in_imm, in_target));
          q_idx.push_back(n_acc);
          n_acc++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [25:0] tgt);
    in_valid  = 1'b1;
    in_type   = t;
    in_op     = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = 5'($urandom);
    in_funct  = fn;
    in_imm    = imm;
    in_target = tgt;
  endtask

  task automatic drive_rand_r();
    drive(2'b00, OP_RTYPE, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
          16'($urandom), 26'($urandom));
  endtask

  logic [5:0] op_tab [8];

  initial begin
    op_tab[0] = OP_RTYPE; op_tab[1] = OP_J;  op_tab[2] = OP_JAL; op_tab[3] = OP_ADDI;
    op_tab[4] = OP_LW;    op_tab[5] = OP_SW; op_tab[6] = OP_BEQ; op_tab[7] = 6'b111111;

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_in_ready",  64'(in_ready_a),  64'd1);
    chk("rst_out_instr", 64'(out_instr_a), 64'd0);
    chk("rst_err",       64'(err_a),       64'd0);
    chk("rst_err_cnt",   64'(err_cnt_a),   64'd0);

    // ADDI, R-type add, J: literal encodings and addresses
    out_ready = 1'b0;
    drive(2'b01, 6'b001000, 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0);
    step();
    in_valid = 1'b0;
    chk("addi_valid", 64'(out_valid_a), 64'd1);
    chk("addi_word",  64'(out_instr_a), 64'h2022_0005);
    chk("addi_addr",  64'(out_addr_a),  64'h0);
    chk("addi_addr_b", 64'(out_addr_b), 64'hFFFF_FFFC);
    drive(2'b00, 6'b000000, 5'd1, 5'd2, 5'd3, 6'b100000, 16'hBEEF, 26'h3FF_FFFF);
    in_shamt = 5'd0;
    step();
    drive(2'b10, 6'b000010, 5'd7, 5'd7, 5'd7, 6'd7, 16'h1234, 26'h010_0000);
    step();
    in_valid = 1'b0;
    chk("hold_word", 64'(out_instr_a), 64'h2022_0005);
    out_ready = 1'b1;
    step();
    chk("add_word",   64'(out_instr_a), 64'h0022_1820);
    chk("add_addr",   64'(out_addr_a),  64'h4);
    chk("add_addr_b", 64'(out_addr_b),  64'h0);
    step();
    chk("j_word", 64'(out_instr_a), 64'h0810_0000);
    chk("j_addr", 64'(out_addr_a),  64'h8);
    step();
    chk("drained", 64'(out_valid_a), 64'd0);
    out_ready = 1'b0;

    // Rejection
    rst = 1'b1; step(); rst = 1'b0;
    drive(2'b11, 6'b001000, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1);
    step();
    in_valid = 1'b0;
    chk("rej_err",   64'(err_a),       64'd1);
    chk("rej_cnt",   64'(err_cnt_a),   64'd1);
    chk("rej_valid", 64'(out_valid_a), 64'd0);
`ifdef INSTR_TYPE_CHECK_EN
    drive(2'b00, 6'b001000, 5'd1, 5'd2, 5'd3, 6'd0, 16'd0, 26'd0);
    step();
    in_valid = 1'b0;
    chk("rej_mismatch_cnt", 64'(err_cnt_a), 64'd2);
`endif
    drive(2'b01, OP_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0);
    step();
    in_valid = 1'b0;
    chk("after_rej_addr", 64'(out_addr_a), 64'h0);
    chk("err_sticky",     64'(err_a),      64'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Backpressure: four accepts fill the FIFO, fifth waits
    for (int i = 0; i < 4; i++) begin
      drive_rand_r();
      step();
    end
    drive_rand_r();
    chk("bp_full_ready", 64'(in_ready_a), 64'd0);
    out_ready = 1'b1;
    chk("bp_full_ready_pop", 64'(in_ready_a), 64'd0);
    step();
    out_ready = 1'b0;
    chk("bp_ready_after_pop", 64'(in_ready_a), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_refull", 64'(in_ready_a), 64'd0);
    out_ready = 1'b1;
    repeat (5) step();
    out_ready = 1'b0;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_type   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      in_op     = op_tab[$urandom_range(0, 7)];
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_shamt  = 5'($urandom);
      in_funct  = 6'($urandom);
      in_imm    = 16'($urandom);
      in_target = 26'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;

    // Saturation
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b1;
    drive(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    repeat (300) step();
    in_valid = 1'b0;
    chk("sat_cnt", 64'(err_cnt_a), 64'd255);
    chk("sat_err", 64'(err_a),     64'd1);

    // Reset mid-stream discards buffered words
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand_r();
      step();
    end
    in_valid = 1'b0;
    chk("mid_buffered", 64'(out_valid_a), 64'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_valid",   64'(out_valid_a), 64'd0);
    chk("mid_err",     64'(err_a),       64'd0);
    chk("mid_err_cnt", 64'(err_cnt_a),   64'd0);
    step();
    chk("mid_idle", 64'(out_valid_a), 64'd0);
    drive(2'b01, OP_LW, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0);
    step();
    in_valid = 1'b0;
    chk("mid_addr",   64'(out_addr_a),  64'h0);
    chk("mid_addr_b", 64'(out_addr_b),  64'hFFFF_FFFC);
    chk("mid_word",   64'(out_instr_a), 64'h8C64_0010);
    out_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the team's opcode-to-category decoder: accepts an instruction category plus MIPS fields and assembles the 32-bit MIPS instruction word.
- Buffers encoded words in a small FIFO and tags each with a sequential instruction-memory address.
- Feeds the instruction-memory loader and the testbench program generator.
- Valid/ready handshake on both sides.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 32, width of the emitted byte address.
- BASE_ADDR, 32'h0000_0000, address assigned to the first accepted instruction; must be word-aligned.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  encode request valid.
- in_ready  output  1  request accepted on in_valid & in_ready.
- in_type  input  2  category: 00 R-type, 01 I-type, 10 J-type, 11 illegal.
- in_op  input  6  opcode.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_shamt  input  5  shift amount.
- in_funct  input  6  function code.
- in_imm  input  16  immediate.
- in_target  input  26  jump target (word index).
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer takes word on out_valid & out_ready.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  byte address of out_instr.
- err  output  1  sticky rejection flag.
- err_cnt  output  8  saturating rejection counter.

Behaviour:
- Reset, synchronous: FIFO emptied, out_valid=0, out_instr=0, out_addr=0, next address = BASE_ADDR, err=0, err_cnt=0; in_ready=1 in the first cycle after reset.
- Encoding:
  - R-type = {op, rs, rt, rd, shamt, funct}.
  - I-type = {op, rs, rt, imm}.
  - J-type = {op, target}.
  - Fields not used by the selected format are ignored.
- in_ready = !full. Accept when in_valid & in_ready. The encoded word plus the current next-address are pushed at that edge.
- Latency: a word accepted into an empty FIFO drives out_valid=1 in the next cycle.
- No combinational pass-through from input to output.
- Pop on out_valid & out_ready. out_instr and out_addr hold stable while out_valid & !out_ready.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.
- When full, in_ready=0 even if out_ready=1; the pop frees the slot for the next cycle.
- Address:
  - next-address += 4 per accepted (not rejected) instruction.
  - Wraps modulo 2^ADDR_W, e.g. 0xFFFF_FFFC -> 0x0000_0000.
- in_type=11 is always rejected:
  - Nothing is pushed and the address does not advance.
  - err is set.
  - err_cnt increments, saturating at 255.
- FIFO control states:
  - EMPTY: occupancy 0.
  - PARTIAL: occupancy 1 to DEPTH-1.
  - FULL: occupancy DEPTH.
  - Transitions are by push/pop only.
- Reset mid-operation discards all buffered words. No output is produced until a new accept.

Optional Feature:
- Macro: INSTR_TYPE_CHECK_EN.
- Defined: category/opcode consistency is enforced. A request is rejected (same handling as type 11) when any of these holds:
  - R-type with op != 000000.
  - J-type with op not in {000010, 000011}.
  - I-type with op in {000000, 000010, 000011}.
- Undefined: only type 11 is rejected. in_op is encoded verbatim for all other types.

Decomposition:
- Package instr_pkg holds:
  - Category codes TYPE_R=2'b00, TYPE_I=2'b01, TYPE_J=2'b10, TYPE_BAD=2'b11.
  - Opcode constants OP_RTYPE, OP_J, OP_JAL, OP_ADDI, OP_LW, OP_SW, OP_BEQ.
  - Field bit-position constants.
- The decoder shares instr_pkg.
- One sub-module: instr_fifo, a parameterised synchronous FIFO of width 32+ADDR_W with full/empty outputs. The encoder, the address counter and the checker stay in instr_encoder.

Test Plan:
- ADDI: type=01, op=001000, rs=1, rt=2, imm=5, BASE_ADDR=0 -> next cycle out_instr=0x20220005, out_addr=0x0.
- R-type add then J:
  - type=00, op=0, rs=1, rt=2, rd=3, funct=100000 -> 0x00221820 @0x0.
  - type=10, op=000010, target=0x0100000 -> 0x08100000 @0x4.
- Backpressure: DEPTH=4, out_ready=0, push 5 requests -> in_ready=0 after the 4th accept. out_ready=1 for one cycle -> first word popped, in_ready=1 next cycle, order preserved.
- Rejection:
  - type=11 -> no push, err=1, err_cnt=1, next accepted word still at 0x0.
  - With INSTR_TYPE_CHECK_EN, type=00 op=001000 -> err_cnt=2.
- Wrap and saturation:
  - BASE_ADDR=0xFFFFFFFC, two accepts -> out_addr 0xFFFFFFFC then 0x00000000.
  - 300 rejections -> err_cnt=255.
- Reset mid-stream: 3 words buffered, rst=1 for one cycle -> out_valid=0, err=0, err_cnt=0. Next accept gets out_addr=BASE_ADDR.
